mult_rr_arbiter: RTL and testbench

- Shares one registered multiplier (en-gated, 1-cycle latency, async reset) among NUM_REQ requesters.
- Each requester presents operands under a valid/ready handshake. A round-robin arbiter picks one request per cycle and drives the multiplier enable and operand muxes.
- The product is returned on a single tagged response channel with backpressure.
- Sits between PE-side operand producers and the shared arithmetic resource in the compute datapath.

---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/reg_mult.sv | 34 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/mult_rr_arbiter.sv | 107 ++++++++++
 tb/tb_mult_rr_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the arbitrated shared-multiplier block.
package mult_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_B_WIDTH = 8;
  localparam int DEF_CNT_W   = 16;

  // Smallest r such that 2**r >= n; sizes the requester tag.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-width unsigned product width, so the multiply never truncates.
  function automatic int prod_w(input int aw, input int bw);
    return aw + bw;
  endfunction

endpackage

// File: rtl/reg_mult.sv
// Registered unsigned multiplier: loads a*b when en is high, holds otherwise.
module reg_mult
  import mult_arb_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic [A_WIDTH+B_WIDTH-1:0] prod
);

  localparam int PW = prod_w(A_WIDTH, B_WIDTH);

  logic [PW-1:0] prod_d, prod_q;

  // Next product: new multiply when enabled, otherwise keep the old result.
  always_comb begin
    prod_d = prod_q;
    if (en) prod_d = PW'(a) * PW'(b);
  end

  // Product register, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod_d;
  end

  assign prod = prod_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last winner and
// owns the pointer, which only moves when the caller reports an acceptance.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner,
  output logic               gnt_vld
);

  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr_d, ptr_q;
  int              idx;

  // Pick the first valid requester starting at ptr+1, wrapping around.
  always_comb begin
    winner  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        winner  = ID_W'(idx);
      end
    end
    gnt = gnt_vld ? (NUM_REQ'(1) << winner) : '0;
  end

  // Pointer follows the winner only on an accepted grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = winner;
  end

  // Pointer register; reset so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PTR_RST;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Shares one registered multiplier among NUM_REQ requesters and returns the
// tagged product through a single-entry response slot with backpressure.
module mult_rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ),
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [A_WIDTH+B_WIDTH-1:0]   rsp_prod,
  output logic [CNT_W-1:0]             issue_cnt
);

  localparam int               PW      = prod_w(A_WIDTH, B_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    winner;
  logic               gnt_vld;
  logic               can_issue;
  logic               accept;
  logic [A_WIDTH-1:0] a_sel;
  logic [B_WIDTH-1:0] b_sel;
  logic [PW-1:0]      prod;

  logic               rsp_valid_d, rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_d, rsp_id_q;
  logic [CNT_W-1:0]   issue_cnt_d, issue_cnt_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .winner  (winner),
    .gnt_vld (gnt_vld)
  );

  // Accept when the slot is free or draining; never while reset is held.
  always_comb begin
    can_issue = !rsp_valid_q || rsp_ready;
    accept    = !rst && can_issue && gnt_vld;
    req_ready = accept ? gnt : '0;
    a_sel     = req_a[winner*A_WIDTH +: A_WIDTH];
    b_sel     = req_b[winner*B_WIDTH +: B_WIDTH];
  end

  reg_mult #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .a    (a_sel),
    .b    (b_sel),
    .prod (prod)
  );

  // Slot bookkeeping: load on issue, clear on drain, saturate the counter.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    issue_cnt_d = issue_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = winner;
      if (issue_cnt_q != CNT_MAX) issue_cnt_d = issue_cnt_q + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Slot and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = prod;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter: a vector table plus hand-written
// sequences for reset-in-flight and counter saturation.
module tb_mult_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_prod;
  logic [15:0] issue_cnt;

  logic [3:0]  sat_req_ready;
  logic        sat_rsp_valid;
  logic [1:0]  sat_rsp_id;
  logic [15:0] sat_rsp_prod;
  logic [3:0]  sat_issue_cnt;

  int total;
  int bad;

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [15:0] exp_prod;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[25];

  mult_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .issue_cnt (issue_cnt)
  );

  mult_rr_arbiter #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (sat_req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (sat_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (sat_rsp_id),
    .rsp_prod  (sat_rsp_prod),
    .issue_cnt (sat_issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic rr, input logic [3:0] er,
                              input logic erv, input logic [1:0] eid,
                              input logic [15:0] ep, input int ec);
    vec_t t;
    t.rst = r; t.valid = v; t.a = a; t.b = b; t.rr = rr;
    t.exp_ready = er; t.exp_rv = erv; t.exp_id = eid; t.exp_prod = ep;
    t.exp_cnt = ec;
    return t;
  endfunction

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic rr);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
  endtask

  task automatic checkVector(input int row, input vec_t t);
    int sat;
    sat = (t.exp_cnt > 15) ? 15 : t.exp_cnt;
    checkOutput("req_ready", row, 32'(req_ready), 32'(t.exp_ready));
    checkOutput("rsp_valid", row, 32'(rsp_valid), 32'(t.exp_rv));
    checkOutput("rsp_id",    row, 32'(rsp_id),    32'(t.exp_id));
    checkOutput("rsp_prod",  row, 32'(rsp_prod),  32'(t.exp_prod));
    checkOutput("issue_cnt", row, 32'(issue_cnt), t.exp_cnt);
    checkOutput("sat_cnt",   row, 32'(sat_issue_cnt), sat);
  endtask

  localparam logic [31:0] A_SEQ  = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] B_SEQ  = {8'd10, 8'd10, 8'd10, 8'd10};
  localparam logic [31:0] A_BP   = {8'd0, 8'd7, 8'd255, 8'd0};
  localparam logic [31:0] B_BP   = {8'd0, 8'd9, 8'd255, 8'd0};
  localparam logic [31:0] A_FAIR = {8'd5, 8'd0, 8'd0, 8'd2};
  localparam logic [31:0] B_FAIR = {8'd5, 8'd0, 8'd0, 8'd3};

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // single request, request during reset ignored
    vecs[0]  = mk(1, 4'b0001, 32'd3, 32'd5, 1, 4'b0000, 0, 0, 0,     0);
    vecs[1]  = mk(0, 4'b0001, 32'd3, 32'd5, 1, 4'b0001, 0, 0, 0,     0);
    vecs[2]  = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 1, 0, 15,    1);
    // round robin over all four
    vecs[3]  = mk(1, 4'b1111, A_SEQ, B_SEQ, 1, 4'b0000, 0, 0, 0,     0);
    vecs[4]  = mk(0, 4'b1111, A_SEQ, B_SEQ, 1, 4'b0001, 0, 0, 0,     0);
    vecs[5]  = mk(0, 4'b1111, A_SEQ, B_SEQ, 1, 4'b0010, 1, 0, 10,    1);
    vecs[6]  = mk(0, 4'b1111, A_SEQ, B_SEQ, 1, 4'b0100, 1, 1, 20,    2);
    vecs[7]  = mk(0, 4'b1111, A_SEQ, B_SEQ, 1, 4'b1000, 1, 2, 30,    3);
    vecs[8]  = mk(0, 4'b1111, A_SEQ, B_SEQ, 1, 4'b0001, 1, 3, 40,    4);
    vecs[9]  = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 1, 0, 10,    5);
    vecs[10] = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 0, 0, 10,    5);
    // backpressure
    vecs[11] = mk(0, 4'b0010, A_BP,  B_BP,  1, 4'b0010, 0, 0, 10,    5);
    vecs[12] = mk(0, 4'b0100, A_BP,  B_BP,  0, 4'b0000, 1, 1, 65025, 6);
    vecs[13] = mk(0, 4'b0100, A_BP,  B_BP,  0, 4'b0000, 1, 1, 65025, 6);
    vecs[14] = mk(0, 4'b0100, A_BP,  B_BP,  0, 4'b0000, 1, 1, 65025, 6);
    vecs[15] = mk(0, 4'b0100, A_BP,  B_BP,  1, 4'b0100, 1, 1, 65025, 6);
    vecs[16] = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 1, 2, 63,    7);
    vecs[17] = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0000, 0, 2, 63,    7);
    // fairness: req3 joins a continuously valid req0
    vecs[18] = mk(0, 4'b0001, A_FAIR, B_FAIR, 1, 4'b0001, 0, 2, 63,  7);
    vecs[19] = mk(0, 4'b0001, A_FAIR, B_FAIR, 1, 4'b0001, 1, 0, 6,   8);
    vecs[20] = mk(0, 4'b0001, A_FAIR, B_FAIR, 1, 4'b0001, 1, 0, 6,   9);
    vecs[21] = mk(0, 4'b1001, A_FAIR, B_FAIR, 1, 4'b1000, 1, 0, 6,   10);
    vecs[22] = mk(0, 4'b1001, A_FAIR, B_FAIR, 1, 4'b0001, 1, 3, 25,  11);
    vecs[23] = mk(0, 4'b1001, A_FAIR, B_FAIR, 1, 4'b1000, 1, 0, 6,   12);
    vecs[24] = mk(0, 4'b0000, 32'd0, 32'd0,   1, 4'b0000, 1, 3, 25,  13);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rr);
      checkVector(i, vecs[i]);
    end

    // reset while a result (6*7=42) sits in the slot
    applyStimulus(0, 4'b0001, 32'd6, 32'd7, 0);
    checkOutput("rst_seq_ready", 100, 32'(req_ready), 32'd1);
    applyStimulus(0, 4'b0000, 32'd0, 32'd0, 0);
    checkOutput("rst_seq_valid", 101, 32'(rsp_valid), 32'd1);
    checkOutput("rst_seq_prod",  101, 32'(rsp_prod),  32'd42);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 102, 32'(rsp_valid), 32'd0);
    checkOutput("rst_async_prod",  102, 32'(rsp_prod),  32'd0);
    checkOutput("rst_async_cnt",   102, 32'(issue_cnt), 32'd0);
    checkOutput("rst_async_ready", 102, 32'(req_ready), 32'd0);
    applyStimulus(0, 4'b1111, A_SEQ, B_SEQ, 1);
    checkOutput("rst_first_winner", 103, 32'(req_ready), 32'd1);

    // counter saturation: 20 accepts in total, then a few more
    for (int i = 0; i < 19; i++) begin
      applyStimulus(0, 4'b0001, A_SEQ, B_SEQ, 1);
      checkOutput("sat_ready", 200 + i, 32'(req_ready), 32'd1);
    end
    applyStimulus(0, 4'b0000, 32'd0, 32'd0, 1);
    checkOutput("cnt_20",     220, 32'(issue_cnt),     32'd20);
    checkOutput("sat_cnt_20", 220, 32'(sat_issue_cnt), 32'd15);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0001, A_SEQ, B_SEQ, 1);
    applyStimulus(0, 4'b0000, 32'd0, 32'd0, 1);
    checkOutput("cnt_23",     221, 32'(issue_cnt),     32'd23);
    checkOutput("sat_cnt_23", 221, 32'(sat_issue_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
